// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, request-type enum and encoder types.
// Used by the instruction encoder and reusable by the main decoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    REQ_R      = 3'b000,
    REQ_I      = 3'b001,
    REQ_LOAD   = 3'b010,
    REQ_STORE  = 3'b011,
    REQ_BRANCH = 3'b100,
    REQ_JAL    = 3'b101
  } req_type_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_FULL   = 1'b1
  } enc_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        legal;
  } pack_t;

  // True when v is representable as a signed value of the given bit width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packing and immediate range check; zero latency.
// No flow control: output follows inputs, legal=0 for bad type or out-of-range imm.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  req_type,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
  output pack_t       pack
);

  always_comb begin
    pack.instr = '0;
    pack.legal = 1'b0;
    case (req_type_e'(req_type))
      REQ_R: begin
        pack.instr = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
        pack.legal = 1'b1;
      end
      REQ_I: begin
        // Shifts carry funct7b5 in the upper immediate and only a 5-bit shamt.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          pack.instr = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, OP_IMM};
        else
          pack.instr = {imm[11:0], rs1, funct3, rd, OP_IMM};
        pack.legal = fits_signed(imm, 12);
      end
      REQ_LOAD: begin
        pack.instr = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        pack.legal = fits_signed(imm, 12);
      end
      REQ_STORE: begin
        pack.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        pack.legal = fits_signed(imm, 12);
      end
      REQ_BRANCH: begin
        pack.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        pack.legal = fits_signed(imm, 13) && !imm[0];
      end
      REQ_JAL: begin
        pack.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        pack.legal = fits_signed(imm, 21) && !imm[0];
      end
      default: begin
        pack.instr = '0;
        pack.legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes requests into RV32I words and writes them to sequential memory; write 1 cycle after accept.
// Backpressure: req_ready low while full or during clr; illegal requests are consumed and flag err.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  enc_state_e      state_q, state_d;
  pack_t           pack;
  logic            accept, write_ok;
  logic            we_q, err_q;
  logic [31:0]     addr_q, wdata_q;
  logic [ADDR_W:0] wc_q;

  instr_pack u_pack (
    .req_type (req_type),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .imm      (imm),
    .pack     (pack)
  );

  assign accept   = req_valid && req_ready;
  assign write_ok = accept && pack.legal;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACCEPT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr)
      state_d = ST_ACCEPT;
    else if (state_q == ST_ACCEPT && write_ok && wc_q == LAST)
      state_d = ST_FULL;
  end

  always_comb begin
    full      = (state_q == ST_FULL);
    req_ready = !full && !clr;
  end

  // word_count advances on the same edge that raises mem_we, so the
  // next back-to-back request already sees the updated slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      wc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q <= write_ok;
      if (write_ok) begin
        addr_q  <= BASE_ADDR + (32'(wc_q) << 2);
        wdata_q <= pack.instr;
      end
      if (clr) begin
        wc_q  <= '0;
        err_q <= 1'b0;
      end else begin
        if (write_ok)
          wc_q <= wc_q + (ADDR_W+1)'(1);
        if (accept && !pack.legal)
          err_q <= 1'b1;
      end
    end
  end

  assign mem_we     = we_q && !clr && !rst;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = wc_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed table-driven bench for instr_encoder (4-word memory) plus fill/clr/rst sequences.
module tb_instr_encoder;

  localparam int          AW   = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, clr, req_valid, req_ready;
  logic [2:0]  req_type;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] imm;
  logic        mem_we, full, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [AW:0] word_count;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7b5(funct7b5), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .word_count(word_count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic        ok;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [18];
  int   total = 0;
  int   bad   = 0;
  int   cnt   = 0;
  logic err_m = 1'b0;

  function automatic vec_t mk(input logic [2:0] t, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                              input logic [4:0] rs2_i, input logic [2:0] f3_i, input logic f7_i,
                              input logic [31:0] imm_i, input logic ok_i, input logic [31:0] exp_i);
    vec_t v;
    v.t = t; v.rd = rd_i; v.rs1 = rs1_i; v.rs2 = rs2_i; v.f3 = f3_i; v.f7 = f7_i;
    v.imm = imm_i; v.ok = ok_i; v.exp = exp_i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    req_type = v.t; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7b5 = v.f7; imm = v.imm;
  endtask

  initial begin
    vt[0]  = mk(3'd0, 5'd3,  5'd1,  5'd2,  3'd0, 1'b0, 32'h0,        1'b1, 32'h002081B3);
    vt[1]  = mk(3'd3, 5'd0,  5'd1,  5'd2,  3'd2, 1'b0, 32'd8,        1'b1, 32'h0020A423);
    vt[2]  = mk(3'd1, 5'd5,  5'd0,  5'd0,  3'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 32'hFFF00293);
    vt[3]  = mk(3'd5, 5'd1,  5'd7,  5'd9,  3'd3, 1'b0, 32'd8,        1'b1, 32'h008000EF);
    vt[4]  = mk(3'd4, 5'd0,  5'd1,  5'd2,  3'd0, 1'b0, 32'd3,        1'b0, 32'h0);
    vt[5]  = mk(3'd4, 5'd0,  5'd1,  5'd2,  3'd0, 1'b0, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3);
    vt[6]  = mk(3'd2, 5'd4,  5'd2,  5'd0,  3'd2, 1'b0, 32'd2047,     1'b1, 32'h7FF12203);
    vt[7]  = mk(3'd1, 5'd4,  5'd2,  5'd0,  3'd0, 1'b0, 32'd2048,     1'b0, 32'h0);
    vt[8]  = mk(3'd6, 5'd1,  5'd1,  5'd1,  3'd0, 1'b0, 32'h0,        1'b0, 32'h0);
    vt[9]  = mk(3'd1, 5'd6,  5'd7,  5'd0,  3'd5, 1'b1, 32'd35,       1'b1, 32'h4033D313);
    vt[10] = mk(3'd5, 5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 32'd5,        1'b0, 32'h0);
    vt[11] = mk(3'd0, 5'd10, 5'd11, 5'd12, 3'd0, 1'b1, 32'h12345,    1'b1, 32'h40C58533);
    vt[12] = mk(3'd3, 5'd0,  5'd3,  5'd4,  3'd0, 1'b0, 32'hFFFFF800, 1'b1, 32'h80418023);
    vt[13] = mk(3'd5, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h000FFFFE, 1'b1, 32'h7FFFF06F);
    vt[14] = mk(3'd5, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00100000, 1'b0, 32'h0);
    vt[15] = mk(3'd4, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'd4096,     1'b0, 32'h0);
    vt[16] = mk(3'd7, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h0,        1'b0, 32'h0);
    vt[17] = mk(3'd4, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'd4094,     1'b1, 32'h7E000FE3);

    rst = 1'b1; clr = 1'b0; req_valid = 1'b0;
    drive(vt[0]);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_we",    mem_we,     0);
    chk("rst_addr",  mem_addr,   BASE);
    chk("rst_wdata", mem_wdata,  0);
    chk("rst_count", word_count, 0);
    chk("rst_full",  full,       0);
    chk("rst_err",   err,        0);
    chk("rst_ready", req_ready,  1);

    for (int i = 0; i < 18; i++) begin
      if (cnt == 4) begin
        clr = 1'b1; step(); clr = 1'b0;
        cnt = 0; err_m = 1'b0;
      end
      drive(vt[i]);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk($sformatf("v%0d_we", i), mem_we, vt[i].ok);
      if (vt[i].ok) begin
        chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].exp);
        chk($sformatf("v%0d_addr", i),  mem_addr,  BASE + 32'(4 * cnt));
        cnt++;
      end else begin
        err_m = 1'b1;
      end
      chk($sformatf("v%0d_count", i), word_count, cnt);
      chk($sformatf("v%0d_err", i),   err,        err_m);
    end

    // Fill a 4-word memory with back-to-back requests after an illegal one.
    clr = 1'b1; step(); clr = 1'b0;
    req_valid = 1'b1;
    drive(mk(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0));
    step();
    chk("ill_err", err,    1);
    chk("ill_we",  mem_we, 0);
    for (int k = 0; k < 5; k++) begin
      drive(mk(3'd0, 5'(k), 5'd0, 5'd0, 3'd0, 1'b0, 32'h0, 1'b1, 32'h0));
      chk($sformatf("b2b%0d_ready", k), req_ready, (k < 4) ? 1 : 0);
      step();
      if (k < 4) begin
        chk($sformatf("b2b%0d_we", k),    mem_we,    1);
        chk($sformatf("b2b%0d_addr", k),  mem_addr,  BASE + 32'(4 * k));
        chk($sformatf("b2b%0d_wdata", k), mem_wdata, (32'(k) << 7) | 32'h33);
      end else begin
        chk("b2b4_we", mem_we, 0);
      end
    end
    chk("fill_full",  full,       1);
    chk("fill_count", word_count, 4);
    chk("fill_ready", req_ready,  0);
    chk("fill_err",   err,        1);

    // Clear while full with err set and a request still offered.
    clr = 1'b1;
    #1;
    chk("clr_ready_low", req_ready, 0);
    step();
    clr = 1'b0;
    #1;
    chk("clr_count", word_count, 0);
    chk("clr_full",  full,       0);
    chk("clr_err",   err,        0);
    chk("clr_we",    mem_we,     0);
    chk("clr_ready", req_ready,  1);
    step();
    req_valid = 1'b0;
    chk("post_clr_we",    mem_we,    1);
    chk("post_clr_addr",  mem_addr,  BASE);
    chk("post_clr_wdata", mem_wdata, 32'h233);

    // clr during the write cycle suppresses mem_we.
    clr = 1'b1;
    #1;
    chk("clr_supp_we", mem_we, 0);
    step();
    clr = 1'b0;
    chk("clr_supp_count", word_count, 0);

    // rst mid-operation discards the pending write and beats clr/requests.
    req_valid = 1'b1;
    drive(vt[8]);
    step();
    drive(vt[0]);
    step();
    chk("pre_rst_we",  mem_we, 1);
    chk("pre_rst_err", err,    1);
    rst = 1'b1; clr = 1'b1;
    #1;
    chk("rst_mid_we", mem_we, 0);
    step();
    rst = 1'b0; clr = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst_mid_we2",   mem_we,     0);
    chk("rst_mid_count", word_count, 0);
    chk("rst_mid_addr",  mem_addr,   BASE);
    chk("rst_mid_wdata", mem_wdata,  0);
    chk("rst_mid_err",   err,        0);
    chk("rst_mid_full",  full,       0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
